// File: rtl/pe_dbuf_mac_if.sv
// Bundle of the PE's control, weight-chain and datapath signals.
// The array controller / neighbouring PEs sit on the master side; the PE is the slave.
interface pe_dbuf_mac_if #(
  parameter int DATAWIDTH = 8,
  parameter int ACCWIDTH  = 32
);
  logic                        mode;
  logic                        wt_load;
  logic signed [DATAWIDTH-1:0] wt_in;
  logic                        wt_swap;
  logic signed [DATAWIDTH-1:0] wt_out;
  logic                        valid_in;
  logic signed [DATAWIDTH-1:0] in_A;
  logic signed [ACCWIDTH-1:0]  in_B;
  logic                        drain;
  logic                        acc_clr;
  logic signed [ACCWIDTH-1:0]  out_D;
  logic                        valid_out;
  logic signed [DATAWIDTH-1:0] out_R;
  logic                        valid_R;
  logic                        ovf;

  modport master (
    output mode, wt_load, wt_in, wt_swap, valid_in, in_A, in_B, drain, acc_clr,
    input  wt_out, out_D, valid_out, out_R, valid_R, ovf
  );

  modport slave (
    input  mode, wt_load, wt_in, wt_swap, valid_in, in_A, in_B, drain, acc_clr,
    output wt_out, out_D, valid_out, out_R, valid_R, ovf
  );
endinterface

// File: rtl/pe_dbuf_mac.sv
// Signed MAC processing element with a double-buffered weight (shadow/active),
// daisy-chained weight load, weight-stationary and output-stationary modes,
// optional saturation and a sticky overflow flag. All outputs are registered.
module pe_dbuf_mac #(
  parameter int DATAWIDTH = 8,
  parameter int ACCWIDTH  = 32,
  parameter bit SATURATE  = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  pe_dbuf_mac_if.slave bus
);

  // Sums are formed one bit wider than the accumulator so that a single
  // add of two in-range operands can never lose its true sign.
  localparam int SUMW  = ACCWIDTH + 1;
  localparam int PRODW = 2 * DATAWIDTH;

  localparam logic signed [ACCWIDTH-1:0] ACC_MAX = {1'b0, {(ACCWIDTH-1){1'b1}}};
  localparam logic signed [ACCWIDTH-1:0] ACC_MIN = {1'b1, {(ACCWIDTH-1){1'b0}}};

  // A wide sum is out of range when its top two bits disagree.
  function automatic logic out_of_range(input logic signed [SUMW-1:0] x);
    return (x[SUMW-1] != x[SUMW-2]);
  endfunction

  // Reduce a wide sum to ACCWIDTH bits: clamp or wrap depending on SATURATE.
  function automatic logic signed [ACCWIDTH-1:0] sat(input logic signed [SUMW-1:0] x);
    logic signed [ACCWIDTH-1:0] r;
    if (!out_of_range(x)) begin
      r = x[ACCWIDTH-1:0];
    end else if (SATURATE) begin
      r = x[SUMW-1] ? ACC_MIN : ACC_MAX;
    end else begin
      r = x[ACCWIDTH-1:0];
    end
    return r;
  endfunction

  function automatic logic signed [SUMW-1:0] sext_acc(input logic signed [ACCWIDTH-1:0] x);
    return {x[ACCWIDTH-1], x};
  endfunction

  // State
  logic signed [DATAWIDTH-1:0] shadow_r;
  logic signed [DATAWIDTH-1:0] active_r;
  logic signed [ACCWIDTH-1:0]  acc_r;
  logic signed [ACCWIDTH-1:0]  out_d_r;
  logic                        valid_out_r;
  logic signed [DATAWIDTH-1:0] out_r_r;
  logic                        valid_r_r;
  logic                        ovf_r;
  logic                        mode_r;

  // Datapath / next-state
  logic signed [PRODW-1:0]    prod_s;
  logic signed [SUMW-1:0]     prod_x_s;
  logic signed [SUMW-1:0]     acc_base_s;
  logic signed [SUMW-1:0]     ws_sum_s;
  logic signed [SUMW-1:0]     os_sum_s;
  logic                       mode_chg_s;
  logic signed [ACCWIDTH-1:0] acc_s;
  logic signed [ACCWIDTH-1:0] out_d_s;
  logic                       valid_out_s;
  logic                       ovf_s;
  logic                       ovf_set_s;

  // The MAC always uses the active weight as it stood before this edge, so a
  // swap only affects MACs issued from the following cycle.
  assign prod_s     = PRODW'(bus.in_A) * PRODW'(active_r);
  assign prod_x_s   = {{(SUMW-PRODW){prod_s[PRODW-1]}}, prod_s};
  assign mode_chg_s = (bus.mode != mode_r);
  // A mode change discards the accumulator; any MAC that cycle starts from zero.
  assign acc_base_s = mode_chg_s ? {SUMW{1'b0}} : sext_acc(acc_r);
  assign ws_sum_s   = prod_x_s + sext_acc(bus.in_B);
  assign os_sum_s   = acc_base_s + (bus.valid_in ? prod_x_s : {SUMW{1'b0}});

  // Next accumulator, result, valid and overflow for the current mode.
  always_comb begin
    acc_s       = acc_r;
    out_d_s     = out_d_r;
    valid_out_s = 1'b0;
    ovf_set_s   = 1'b0;
    ovf_s       = ovf_r;
    if (!bus.mode) begin
      // Weight-stationary: partial sum flows down, drain is ignored.
      if (bus.valid_in) begin
        out_d_s     = sat(ws_sum_s);
        valid_out_s = 1'b1;
        ovf_set_s   = out_of_range(ws_sum_s);
      end else begin
        out_d_s     = out_d_r;
      end
      acc_s = acc_base_s[ACCWIDTH-1:0];
    end else begin
      // Output-stationary: accumulate locally, emit on drain (which may carry a last MAC).
      if (bus.drain) begin
        out_d_s     = sat(os_sum_s);
        valid_out_s = 1'b1;
        ovf_set_s   = out_of_range(os_sum_s);
        acc_s       = {ACCWIDTH{1'b0}};
      end else if (bus.valid_in) begin
        acc_s       = sat(os_sum_s);
        ovf_set_s   = out_of_range(os_sum_s);
      end else begin
        acc_s       = acc_base_s[ACCWIDTH-1:0];
      end
    end
    // Clear wins over accumulation and over any overflow raised this cycle;
    // a coincident drain has already captured the pre-clear accumulator.
    if (bus.acc_clr) begin
      acc_s = {ACCWIDTH{1'b0}};
      ovf_s = 1'b0;
    end else begin
      ovf_s = ovf_r | ovf_set_s;
    end
  end

  // Weight chain: shadow shifts from above, active takes the old shadow on swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= {DATAWIDTH{1'b0}};
      active_r <= {DATAWIDTH{1'b0}};
    end else begin
      if (bus.wt_load) shadow_r <= bus.wt_in;
      if (bus.wt_swap) active_r <= shadow_r;
    end
  end

  // Accumulator, result, flags and previous-mode tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= {ACCWIDTH{1'b0}};
      out_d_r     <= {ACCWIDTH{1'b0}};
      valid_out_r <= 1'b0;
      ovf_r       <= 1'b0;
      mode_r      <= 1'b0;
    end else begin
      acc_r       <= acc_s;
      out_d_r     <= out_d_s;
      valid_out_r <= valid_out_s;
      ovf_r       <= ovf_s;
      mode_r      <= bus.mode;
    end
  end

  // Activation forwarding to the right neighbour; data only moves when valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r_r   <= {DATAWIDTH{1'b0}};
      valid_r_r <= 1'b0;
    end else begin
      valid_r_r <= bus.valid_in;
      if (bus.valid_in) out_r_r <= bus.in_A;
    end
  end

  assign bus.wt_out    = shadow_r;
  assign bus.out_D     = out_d_r;
  assign bus.valid_out = valid_out_r;
  assign bus.out_R     = out_r_r;
  assign bus.valid_R   = valid_r_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_pe_dbuf_mac.sv
// Bench for pe_dbuf_mac: two 16-bit-accumulator instances (saturating and
// wrapping) share one stimulus stream and are compared every cycle against an
// arithmetic reference model; directed scenarios add fixed expected values.
module tb_pe_dbuf_mac;

  localparam longint MAXV = 64'sd32767;
  localparam longint MINV = -64'sd32768;
  localparam longint SPAN = 64'sd65536;

  logic clk;
  logic rst_n;
  logic mode, wt_load, wt_swap, valid_in, drain, acc_clr;
  logic signed [7:0]  wt_in, in_a;
  logic signed [15:0] in_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (index 0 = saturating, 1 = wrapping)
  longint m_shadow, m_active, m_outr;
  bit     m_vr, m_pmode;
  longint m_acc [2];
  longint m_out [2];
  bit     m_vout[2];
  bit     m_ovf [2];

  pe_dbuf_mac_if #(.DATAWIDTH(8), .ACCWIDTH(16)) ifs ();
  pe_dbuf_mac_if #(.DATAWIDTH(8), .ACCWIDTH(16)) ifw ();

  assign ifs.mode = mode;       assign ifw.mode = mode;
  assign ifs.wt_load = wt_load; assign ifw.wt_load = wt_load;
  assign ifs.wt_in = wt_in;     assign ifw.wt_in = wt_in;
  assign ifs.wt_swap = wt_swap; assign ifw.wt_swap = wt_swap;
  assign ifs.valid_in = valid_in; assign ifw.valid_in = valid_in;
  assign ifs.in_A = in_a;       assign ifw.in_A = in_a;
  assign ifs.in_B = in_b;       assign ifw.in_B = in_b;
  assign ifs.drain = drain;     assign ifw.drain = drain;
  assign ifs.acc_clr = acc_clr; assign ifw.acc_clr = acc_clr;

  pe_dbuf_mac #(.DATAWIDTH(8), .ACCWIDTH(16), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(ifs));
  pe_dbuf_mac #(.DATAWIDTH(8), .ACCWIDTH(16), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(ifw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit oor(input longint x);
    return (x > MAXV) || (x < MINV);
  endfunction

  function automatic longint fit(input longint x, input bit satur);
    if (x > MAXV) return satur ? MAXV : x - SPAN;
    if (x < MINV) return satur ? MINV : x + SPAN;
    return x;
  endfunction

  task automatic model_reset();
    m_shadow = 0; m_active = 0; m_outr = 0; m_vr = 1'b0; m_pmode = 1'b0;
    for (int v = 0; v < 2; v++) begin
      m_acc[v] = 0; m_out[v] = 0; m_vout[v] = 1'b0; m_ovf[v] = 1'b0;
    end
  endtask

  // One rising edge of the reference PE, using the inputs currently applied.
  task automatic model_edge();
    longint prod, base, s;
    prod = longint'(in_a) * m_active;
    for (int v = 0; v < 2; v++) begin
      base = (mode != m_pmode) ? 0 : m_acc[v];
      m_vout[v] = 1'b0;
      if (!mode) begin
        if (valid_in) begin
          s = prod + longint'(in_b);
          m_out[v] = fit(s, v == 0);
          m_vout[v] = 1'b1;
          if (oor(s)) m_ovf[v] = 1'b1;
        end
        m_acc[v] = base;
      end else if (drain) begin
        s = base + (valid_in ? prod : 0);
        m_out[v] = fit(s, v == 0);
        m_vout[v] = 1'b1;
        m_acc[v] = 0;
        if (oor(s)) m_ovf[v] = 1'b1;
      end else if (valid_in) begin
        s = base + prod;
        m_acc[v] = fit(s, v == 0);
        if (oor(s)) m_ovf[v] = 1'b1;
      end else begin
        m_acc[v] = base;
      end
      if (acc_clr) begin
        m_acc[v] = 0;
        m_ovf[v] = 1'b0;
      end
    end
    m_pmode = mode;
    m_vr = valid_in;
    if (valid_in) m_outr = longint'(in_a);
    if (wt_swap) m_active = m_shadow;
    if (wt_load) m_shadow = longint'(wt_in);
  endtask

  task automatic check_all();
    check("s_out_D", longint'(ifs.out_D), m_out[0]);
    check("w_out_D", longint'(ifw.out_D), m_out[1]);
    check("s_valid_out", longint'(ifs.valid_out), longint'(m_vout[0]));
    check("w_valid_out", longint'(ifw.valid_out), longint'(m_vout[1]));
    check("s_ovf", longint'(ifs.ovf), longint'(m_ovf[0]));
    check("w_ovf", longint'(ifw.ovf), longint'(m_ovf[1]));
    check("s_out_R", longint'(ifs.out_R), m_outr);
    check("w_out_R", longint'(ifw.out_R), m_outr);
    check("s_valid_R", longint'(ifs.valid_R), longint'(m_vr));
    check("w_valid_R", longint'(ifw.valid_R), longint'(m_vr));
    check("s_wt_out", longint'(ifs.wt_out), m_shadow);
    check("w_wt_out", longint'(ifw.wt_out), m_shadow);
  endtask

  // Advance one clock, update the model at the edge, compare just after it.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit ld, input int wi, input bit sw, input bit va,
                       input int a, input int b, input bit dr, input bit clr);
    wt_load = ld; wt_in = 8'(wi); wt_swap = sw; valid_in = va;
    in_a = 8'(a); in_b = 16'(b); drain = dr; acc_clr = clr;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all();
    check("rst_out_D", longint'(ifs.out_D), 0);
    rst_n = 1'b1;

    // Double-buffered weight: active 3, shadow 5, then swap
    drive(1, 3, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0, 0, 0, 0); step();
    drive(1, 5, 0, 0, 0, 0, 0, 0); step();
    check("dbuf_wt_out", longint'(ifs.wt_out), 5);
    drive(0, 0, 0, 1, 2, 10, 0, 0); step();
    check("dbuf_old_w", longint'(ifs.out_D), 16);
    drive(0, 0, 1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 2, 10, 0, 0); step();
    check("dbuf_new_w", longint'(ifs.out_D), 20);
    check("dbuf_wt_out2", longint'(ifs.wt_out), 5);

    // Simultaneous load and swap
    drive(1, 4, 0, 0, 0, 0, 0, 0); step();
    drive(1, 5, 1, 0, 0, 0, 0, 0); step();
    drive(1, 7, 1, 0, 0, 0, 0, 0); step();
    check("ldsw_wt_out", longint'(ifs.wt_out), 7);
    drive(0, 0, 0, 1, 1, 0, 0, 0); step();
    check("ldsw_active", longint'(ifs.out_D), 5);

    // WS stream 1,0,1
    drive(1, 6, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, -4, 1, 0, 0); step();
    check("ws_b0_out", longint'(ifs.out_D), -23);
    check("ws_b0_vout", longint'(ifs.valid_out), 1);
    check("ws_b0_outR", longint'(ifs.out_R), -4);
    drive(0, 0, 0, 0, 5, 1, 0, 0); step();
    check("ws_b1_out", longint'(ifs.out_D), -23);
    check("ws_b1_vout", longint'(ifs.valid_out), 0);
    check("ws_b1_outR", longint'(ifs.out_R), -4);
    check("ws_b1_vR", longint'(ifs.valid_R), 0);
    drive(0, 0, 0, 1, -4, 1, 0, 0); step();
    check("ws_b2_out", longint'(ifs.out_D), -23);
    check("ws_b2_vout", longint'(ifs.valid_out), 1);

    // OS accumulate and drain
    drive(1, 2, 0, 0, 0, 0, 0, 0); step();
    mode = 1'b1;
    drive(0, 0, 1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 1, 0, 0, 0); step();
    check("os_acc1_vout", longint'(ifs.valid_out), 0);
    drive(0, 0, 0, 1, 2, 0, 0, 0); step();
    drive(0, 0, 0, 1, 3, 0, 1, 0); step();
    check("os_drain_out", longint'(ifs.out_D), 12);
    check("os_drain_vout", longint'(ifs.valid_out), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    check("os_pulse_end", longint'(ifs.valid_out), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    check("os_drain_empty", longint'(ifs.out_D), 0);
    check("os_drain_empty_v", longint'(ifs.valid_out), 1);
    drive(0, 0, 0, 1, 5, 0, 0, 0); step();
    drive(0, 0, 0, 1, 1, 0, 1, 1); step();
    check("os_clr_drain", longint'(ifs.out_D), 12);
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    check("os_after_clr", longint'(ifs.out_D), 0);

    // Saturation vs wrap in WS
    mode = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 127, 32760, 0, 0); step();
    check("sat_out", longint'(ifs.out_D), 32767);
    check("sat_ovf", longint'(ifs.ovf), 1);
    check("wrap_out", longint'(ifw.out_D), -32649);
    check("wrap_ovf", longint'(ifw.ovf), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1); step();
    check("sat_ovf_clr", longint'(ifs.ovf), 0);
    check("wrap_ovf_clr", longint'(ifw.ovf), 0);

    // Asynchronous reset in the middle of an OS accumulation
    mode = 1'b1;
    drive(1, 5, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 10, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("arst_out_D", longint'(ifs.out_D), 0);
    check("arst_wt_out", longint'(ifs.wt_out), 0);
    check("arst_out_R", longint'(ifs.out_R), 0);
    #2 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    check("arst_drain", longint'(ifs.out_D), 0);
    check("arst_drain_v", longint'(ifs.valid_out), 1);

    // Randomised traffic; mode only changes and acc_clr only fires on idle cycles
    for (int i = 0; i < 800; i++) begin
      bit va, dr, clr;
      va  = ($urandom_range(0, 9) < 6);
      dr  = ($urandom_range(0, 4) == 0);
      clr = 1'b0;
      if (!va && !dr) begin
        clr = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 9) == 0) mode = ~mode;
      end
      drive($urandom_range(0, 1), int'($urandom), ($urandom_range(0, 3) == 0), va,
            int'($urandom), int'($urandom), dr, clr);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pe_dbuf_mac.md
# pe_dbuf_mac

Parametrised successor to the systolic-array processing element. It is a signed MAC cell with a double-buffered weight register and a daisy-chained weight-load path, so the next weight tile shifts in while the current tile computes. It runs in two modes: weight-stationary, which passes partial sums down, and output-stationary, which accumulates locally and drains on command. It adds valid propagation, optional saturation and a sticky overflow flag, and tiles into the same row/column grid as the existing array.

## Interface
- DATAWIDTH, 8, signed width of activations and weights
- ACCWIDTH, 32, signed width of partial sum and accumulator
- SATURATE, 1, 1 = clamp results to ACCWIDTH signed range; 0 = two's-complement wrap
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mode  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS)
- wt_load  in  1  shift wt_in into shadow weight register
- wt_in  in  DATAWIDTH  weight from PE above (or array edge)
- wt_swap  in  1  copy shadow weight into active weight
- wt_out  out  DATAWIDTH  shadow weight, to wt_in of PE below
- valid_in  in  1  in_A (and in_B in WS) valid this cycle
- in_A  in  DATAWIDTH  activation from left
- in_B  in  ACCWIDTH  partial sum from above (WS only; ignored in OS)
- drain  in  1  OS: emit accumulator on out_D
- acc_clr  in  1  clear accumulator and ovf
- out_D  out  ACCWIDTH  result / partial sum downward
- valid_out  out  1  out_D valid
- out_R  out  DATAWIDTH  registered in_A, to right neighbour
- valid_R  out  1  registered valid_in, to right neighbour
- ovf  out  1  sticky: a saturation/wrap event occurred

## Operation
- Reset: out_D, out_R, wt_out, shadow, active weight, accumulator = 0; valid_out, valid_R, ovf = 0.
- Weight chain: wt_load=1 → shadow <= wt_in. wt_out always equals shadow. An N-deep column loads in N cycles with wt_load held.
- wt_swap=1 → active <= shadow.
- Simultaneous wt_load and wt_swap: active gets the old shadow and shadow gets the new wt_in.
- A swap takes effect for MACs issued from the next cycle onward.
- prod = in_A * active, sign-extended; sums are computed at ACCWIDTH+1 bits, then passed through the sat function.
- sat: with SATURATE=1, clamp to [-2^(ACCWIDTH-1), 2^(ACCWIDTH-1)-1]; with SATURATE=0, truncate. Either way, ovf <= 1 on out-of-range.
- Forwarding: valid_R <= valid_in every cycle. out_R <= in_A only when valid_in, else it holds. This applies in both modes.
- WS, valid_in=1: out_D <= sat(prod + in_B), valid_out <= 1.
- WS, valid_in=0: out_D holds, valid_out <= 0.
- OS, valid_in=1, drain=0: acc <= sat(acc + prod). valid_out <= 0 and out_D holds.
- OS, drain=1: out_D <= sat(acc + (valid_in ? prod : 0)), valid_out <= 1, acc <= 0. This means the last MAC can coincide with drain.
- OS, drain=0 and valid_in=0: state holds.
- drain is ignored in WS mode.
- acc_clr=1: acc <= 0, ovf <= 0. It takes priority over accumulation that cycle.
- acc_clr with drain: the drain output still includes the pre-clear acc.
- Mode change, detected against the registered previous mode: acc <= 0 in that cycle, and any MAC in that cycle is processed in the new mode. The controller changes mode only when the array is idle.
- Weight loading and swapping are independent of mode and valid.

## Timing
- WS latency: 1 cycle, in_A/in_B/valid_in to out_D/valid_out. The array skews in_B one cycle per row.
- OS: drain to out_D/valid_out in 1 cycle. valid_out is a single-cycle pulse per drain cycle.
- out_R/valid_R: 1 cycle, so the right neighbour sees data skewed by one cycle per column.
- Weight chain: 1 cycle per PE. wt_swap can issue the cycle after the final wt_load, and all PEs swap in the same cycle.
- No backpressure: downstream must accept every valid_out.
- Async reset mid-operation: all registers clear immediately, including the in-flight accumulator and shadow weight. Operation resumes on the first clk edge after deassertion.

## Test plan
- Weight double buffer: active=3, then shadow loaded 5, then MAC in_A=2, in_B=10 (WS) → out_D=16. Then wt_swap and the same MAC → out_D=20. wt_out=5 throughout after the load.
- Simultaneous wt_load=7 and wt_swap with shadow=5: active=5, shadow/wt_out=7, checked on the next cycle.
- WS stream: valid_in pattern 1,0,1 with in_A=-4, weight=6, in_B=1 → out_D=-23, held at -23, then -23 again. valid_out follows 1,0,1. valid_R/out_R are delayed one cycle.
- OS accumulate and drain: weight=2, in_A=1,2,3 with drain on the third beat → out_D=12, valid_out single pulse, acc=0 afterwards. A following drain with no MAC → out_D=0.
- Saturation (ACCWIDTH=16, SATURATE=1): WS in_B=32760, in_A=127, weight=1 → out_D=32767, ovf=1. With SATURATE=0 → out_D=-32649, ovf=1. acc_clr → ovf=0.
- Reset mid-accumulate: OS acc=50, assert rst_n=0 asynchronously → all outputs 0 before the next edge. Then drain after release → out_D=0.
